// File: rtl/lock_key_pkg.sv
// Shared constants and FSM state encoding for the c499 locking-key loader.
package lock_key_pkg;
  localparam int KEY_W = 36;
  localparam int MUX_W = 4;
  localparam int XOR_W = 32;
  localparam int CNT_W = $clog2(KEY_W + 2);

  localparam logic [KEY_W-1:0] DECOY_KEY = {KEY_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    READY = 3'd3,
    ERROR = 3'd4
  } lk_state_t;

  // Even parity over key plus parity bit holds when the key's XOR equals the parity bit.
  function automatic logic even_par_ok(input logic key_xor, input logic par_bit);
    return (key_xor == par_bit);
  endfunction
endpackage

// File: rtl/lock_key_shreg.sv
// Serial key shift register with bit counter and running parity of the key bits.
module lock_key_shreg
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             take_i,
  input  logic             sdi_i,
  output logic [KEY_W-1:0] shreg_o,
  output logic             done_o,
  output logic             par_ok_o
);
  logic [KEY_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             acc_q, acc_d;
  logic             par_q, par_d;
  logic             parity_beat_s;

  assign parity_beat_s = (count_q == CNT_W'(KEY_W));

  // Next-state for shift data, count, parity accumulator and captured parity bit.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    acc_d   = acc_q;
    par_d   = par_q;
    if (clr_i) begin
      shreg_d = {KEY_W{1'b0}};
      count_d = {CNT_W{1'b0}};
      acc_d   = 1'b0;
      par_d   = 1'b0;
    end else if (take_i) begin
      count_d = count_q + CNT_W'(1);
      if (parity_beat_s) begin
        par_d = sdi_i;
      end else begin
        shreg_d = {shreg_q[KEY_W-2:0], sdi_i};
        acc_d   = acc_q ^ sdi_i;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Shift-path state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= {KEY_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
    end
  end

  assign shreg_o  = shreg_q;
  assign done_o   = take_i && parity_beat_s;
  assign par_ok_o = even_par_ok(acc_q, par_q);
endmodule

// File: rtl/lock_key_loader.sv
// Serial-in, parity-verified key loader; presents a decoy key until a load verifies.
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [MUX_W-1:0] key_p,
  output logic [XOR_W-1:0] key_x,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);
  lk_state_t        state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             key_err_q, key_err_d;
  logic             sdi_ready_q, sdi_ready_d;
  logic             busy_q, busy_d;
  logic [KEY_W-1:0] shreg_s;
  logic             done_s, par_ok_s, take_s, clr_s;

  // sdi_ready_q is high exactly while in SHIFT; a restart takes priority over a data beat.
  assign take_s = sdi_valid && sdi_ready_q && !load_start;
  assign clr_s  = load_start && (state_q != CHECK);

  lock_key_shreg u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr_s),
    .take_i   (take_s),
    .sdi_i    (sdi),
    .shreg_o  (shreg_s),
    .done_o   (done_s),
    .par_ok_o (par_ok_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load_start ? SHIFT : IDLE;
      SHIFT: begin
        if (load_start)  state_d = SHIFT;
        else if (done_s) state_d = CHECK;
        else             state_d = SHIFT;
      end
      CHECK:   state_d = par_ok_s ? READY : ERROR;
      READY:   state_d = load_start ? SHIFT : READY;
      ERROR:   state_d = load_start ? SHIFT : ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; the key is swapped to decoy on the same edge a reload starts.
  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;
    sdi_ready_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT) || (state_d == CHECK);
    case (state_q)
      IDLE: begin
        if (load_start) key_err_d = 1'b0;
        else            key_err_d = key_err_q;
      end
      SHIFT: begin
        key_d       = DECOY_KEY;
        key_valid_d = 1'b0;
      end
      CHECK: begin
        if (par_ok_s) begin
          key_d       = shreg_s;
          key_valid_d = 1'b1;
        end else begin
          key_d       = DECOY_KEY;
          key_valid_d = 1'b0;
          key_err_d   = 1'b1;
        end
      end
      READY: begin
        if (load_start) begin
          key_d       = DECOY_KEY;
          key_valid_d = 1'b0;
        end else begin
          key_valid_d = 1'b1;
        end
      end
      ERROR: begin
        if (load_start) key_err_d = 1'b0;
        else            key_err_d = 1'b1;
      end
      default: begin
        key_d       = DECOY_KEY;
        key_valid_d = 1'b0;
        key_err_d   = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= DECOY_KEY;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      sdi_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      sdi_ready_q <= sdi_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign key_p     = key_q[MUX_W-1:0];
  assign key_x     = key_q[KEY_W-1:MUX_W];
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign sdi_ready = sdi_ready_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_lock_key_loader.sv
// Scoreboard bench for lock_key_loader: stimulus pushes expected load results, a monitor checks them.
module tb_lock_key_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        sdi = 1'b0;
  logic        sdi_valid = 1'b0;
  logic        sdi_ready;
  logic [3:0]  key_p;
  logic [31:0] key_x;
  logic        key_valid;
  logic        key_err;
  logic        busy;

  lock_key_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sdi_ready  (sdi_ready),
    .key_p      (key_p),
    .key_x      (key_x),
    .key_valid  (key_valid),
    .key_err    (key_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        err;
    logic [3:0]  p;
    logic [31:0] x;
    int          lat;
  } exp_t;

  exp_t  sb_q[$];
  int    n_pass = 0;
  int    n_chk = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  logic  prev_v = 1'b0;
  logic  prev_e = 1'b0;

  localparam logic [35:0] KEY_A = 36'hA5A5A5A5A;
  localparam logic [35:0] KEY_1 = 36'h000000001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: a rising key_valid or key_err is a load result; compare with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if ((key_valid && !prev_v) || (key_err && !prev_e)) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: load result seen with empty scoreboard");
      end else begin
        e = sb_q.pop_front();
        chk("key_valid", 64'(key_valid), 64'(e.valid));
        chk("key_err",   64'(key_err),   64'(e.err));
        chk("key_p",     64'(key_p),     64'(e.p));
        chk("key_x",     64'(key_x),     64'(e.x));
        chk("busy",      64'(busy),      64'd0);
        chk("latency",   64'(cyc - start_cyc), 64'(e.lat));
      end
    end
    prev_v = key_valid;
    prev_e = key_err;
  end

  task automatic send_bit(input logic b);
    int tmo = 0;
    sdi_valid = 1'b1;
    sdi = b;
    while (!sdi_ready && tmo < 50) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (!sdi_ready) begin
      n_chk++;
      $display("FAIL ready_timeout: sdi_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_key(input logic [35:0] k, input logic p, input logic gaps);
    for (int i = 35; i >= 0; i--) begin
      send_bit(k[i]);
      if (gaps && ((36 - i) == 5 || (36 - i) == 20)) begin
        sdi_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    send_bit(p);
    sdi_valid = 1'b0;
  endtask

  task automatic send_partial(input logic [35:0] k, input int n);
    for (int i = 0; i < n; i++) send_bit(k[35 - i]);
    sdi_valid = 1'b0;
  endtask

  task automatic push_exp(input logic v, input logic e, input logic [3:0] p,
                          input logic [31:0] x, input int lat);
    exp_t t;
    t.valid = v; t.err = e; t.p = p; t.x = x; t.lat = lat;
    sb_q.push_back(t);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL sb_timeout: %0d load results missing, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_valid"}, 64'(key_valid), 64'd0);
    chk({tag, "_key_err"},   64'(key_err),   64'd0);
    chk({tag, "_key_p"},     64'(key_p),     64'd0);
    chk({tag, "_key_x"},     64'(key_x),     64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_sdi_ready"}, 64'(sdi_ready), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: good load, no gaps
    start_load();
    chk("shift_busy", 64'(busy), 64'd1);
    chk("shift_ready", 64'(sdi_ready), 64'd1);
    push_exp(1'b1, 1'b0, 4'hA, 32'hA5A5A5A5, 38);
    send_key(KEY_A, 1'b0, 1'b0);
    wait_sb();

    // 5: reload from READY drops the key on the same edge
    start_load();
    chk("reload_valid", 64'(key_valid), 64'd0);
    chk("reload_key_p", 64'(key_p), 64'd0);
    chk("reload_key_x", 64'(key_x), 64'd0);
    push_exp(1'b1, 1'b0, 4'h1, 32'h0, 38);
    send_key(KEY_1, 1'b1, 1'b0);
    wait_sb();

    // 2: parity fail then good reload
    start_load();
    push_exp(1'b0, 1'b1, 4'h0, 32'h0, 38);
    send_key(KEY_A, 1'b1, 1'b0);
    wait_sb();
    start_load();
    chk("err_cleared", 64'(key_err), 64'd0);
    push_exp(1'b1, 1'b0, 4'hA, 32'hA5A5A5A5, 38);
    send_key(KEY_A, 1'b0, 1'b0);
    wait_sb();

    // 3: backpressure gaps add six cycles
    start_load();
    push_exp(1'b1, 1'b0, 4'hA, 32'hA5A5A5A5, 44);
    send_key(KEY_A, 1'b0, 1'b1);
    wait_sb();

    // 4: abort after 10 bits, then full load
    start_load();
    send_partial(KEY_A, 10);
    start_load();
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_valid", 64'(key_valid), 64'd0);
    push_exp(1'b1, 1'b0, 4'h1, 32'h0, 38);
    send_key(KEY_1, 1'b1, 1'b0);
    wait_sb();

    // 6: asynchronous reset mid-load
    start_load();
    send_partial(KEY_A, 20);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_load();
    push_exp(1'b1, 1'b0, 4'hA, 32'hA5A5A5A5, 38);
    send_key(KEY_A, 1'b0, 1'b0);
    wait_sb();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
